instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 105 ++++++++++
 tb/tb_instruction_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: prefetches 16-bit instruction words from memory_control into a small FIFO for decode.
// Ports: clk/reset (async, active high); request/request_address/request_type/data_out drive memory_control;
// memory_in/memory_ready return read data; redirect/redirect_pc flush and retarget fetch;
// instr/instr_pc/instr_valid/instr_ready form the decode-side stream.
module instruction_fetch #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] request_address,
  output logic        request_type,
  output logic        request,
  output logic [15:0] data_out,
  input  logic [15:0] memory_in,
  input  logic        memory_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t        state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   request_address_q, request_address_d;
  logic          request_q, request_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d, count_after_pop;
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic          pop, push;
  assign instr_valid     = count_q != '0;
  assign pop             = instr_valid && instr_ready && !redirect;
  assign push            = state_q == WAIT && memory_ready && !redirect;
  assign count_after_pop = count_q - (AW+1)'(pop);
  assign {instr, instr_pc} = fifo_q[rd_ptr_q];
  assign request         = request_q;
  assign request_address = request_address_q;
  assign request_type    = 1'b0;
  assign data_out        = 16'h0000;
  // Pointers return to zero on a flush so the FIFO restarts cleanly after redirect.
  always_comb begin
    rd_ptr_d = redirect ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = redirect ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = redirect ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // A read is only issued when a slot is free after this edge's pop, so the
  // returning word always has room even if decode stalls meanwhile.
  always_comb begin
    state_d           = state_q;
    fetch_pc_d        = redirect ? redirect_pc : fetch_pc_q;
    request_d         = request_q;
    request_address_d = request_address_q;
    case (state_q)
      IDLE: begin
        if (!redirect && count_after_pop < (AW+1)'(FIFO_DEPTH)) begin
          request_d         = 1'b1;
          request_address_d = fetch_pc_q;
          state_d           = WAIT;
        end
      end
      WAIT: begin
        if (memory_ready) begin
          request_d = 1'b0;
          state_d   = IDLE;
          if (!redirect) fetch_pc_d = fetch_pc_q + 16'd1;
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (memory_ready) begin
          request_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      fetch_pc_q        <= RESET_PC;
      request_q         <= 1'b0;
      request_address_q <= 16'h0000;
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      count_q           <= '0;
    end else begin
      state_q           <= state_d;
      fetch_pc_q        <= fetch_pc_d;
      request_q         <= request_d;
      request_address_q <= request_address_d;
      rd_ptr_q          <= rd_ptr_d;
      wr_ptr_q          <= wr_ptr_d;
      count_q           <= count_d;
    end
  end
  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {memory_in, request_address_q};
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of instruction_fetch against a stream-level model.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] request_address;
  logic        request_type;
  logic        request;
  logic [15:0] data_out;
  logic [15:0] memory_in;
  logic        memory_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int          checks = 0;
  int          errors = 0;
  int          total_pops = 0;
  int          age = 0;
  int          lat = 2;
  bit          rand_lat = 1'b0;
  bit          noise = 1'b0;
  logic [15:0] exp_pc = 16'h0000;
  logic [15:0] popped [$];

  always #5 clk = ~clk;

  instruction_fetch #(.FIFO_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .reset(reset),
    .request_address(request_address),
    .request_type(request_type),
    .request(request),
    .data_out(data_out),
    .memory_in(memory_in),
    .memory_ready(memory_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] popped_at(input int k);
    return (popped.size() > k) ? popped[k] : 16'hxxxx;
  endfunction

  // The model tracks only the architectural stream: after reset or a redirect,
  // decode must see consecutive addresses with data = address ^ 16'hA5A5.
  task automatic cycle();
    logic        p_req, p_done, p_redir, p_rst;
    logic [15:0] p_addr;
    p_rst   = reset;
    p_req   = request;
    p_addr  = request_address;
    p_done  = request && memory_ready;
    p_redir = redirect;
    if (reset) begin
      exp_pc = 16'h0000;
      popped.delete();
    end else if (redirect) begin
      exp_pc = redirect_pc;
      popped.delete();
    end else if (instr_valid && instr_ready) begin
      check("pop_pc", instr_pc, exp_pc);
      check("pop_instr", instr, exp_pc ^ 16'hA5A5);
      popped.push_back(instr_pc);
      exp_pc++;
      total_pops++;
    end
    @(posedge clk);
    #1;
    if (!p_rst && !reset) begin
      if (p_req && !p_done) begin
        check("req_hold", request, 1);
        check("addr_hold", request_address, p_addr);
      end
      if (p_done) check("req_gap", request, 0);
      if (p_redir) check("flush", instr_valid, 0);
    end
    if (reset || !request) age = 0;
    else begin
      if (age == 0) lat = rand_lat ? int'($urandom_range(1, 4)) : 2;
      age++;
    end
    memory_ready = (request && !reset) ? (age == lat) : (noise && $urandom_range(0, 3) == 0);
    memory_in    = (memory_ready && request) ? (request_address ^ 16'hA5A5) : 16'($urandom);
  endtask

  initial begin
    int n;
    int start;
    instr_ready  = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 16'h0000;
    memory_ready = 1'b0;
    memory_in    = 16'h0000;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    check("rst_request", request, 0);
    check("rst_addr", request_address, 16'h0000);
    check("rst_type", request_type, 0);
    check("rst_dout", data_out, 16'h0000);
    check("rst_valid", instr_valid, 0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("first_req", request, 1);
    check("first_addr", request_address, 16'h0000);
    repeat (30) cycle();
    check("stall_req", request, 0);
    check("stall_valid", instr_valid, 1);
    check("stall_head", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    cycle();
    check("resume_req", request, 1);
    check("resume_addr", request_address, 16'h0004);
    repeat (12) cycle();
    check("stream_n", popped.size() >= 3, 1);
    check("stream0", popped_at(0), 16'h0000);
    check("stream1", popped_at(1), 16'h0001);
    check("stream2", popped_at(2), 16'h0002);
    n = 0;
    while (!(request && !memory_ready) && n < 50) begin cycle(); n++; end
    check("wait_found", n < 50, 1);
    redirect    = 1'b1;
    redirect_pc = 16'h1234;
    cycle();
    redirect = 1'b0;
    check("redir_valid", instr_valid, 0);
    check("discard_req", request, 1);
    n = 0;
    while (!instr_valid && n < 50) begin cycle(); n++; end
    check("redir_found", n < 50, 1);
    check("redir_pc", instr_pc, 16'h1234);
    check("redir_instr", instr, 16'h1234 ^ 16'hA5A5);
    n = 0;
    while (!(request && memory_ready) && n < 50) begin cycle(); n++; end
    check("ready_found", n < 50, 1);
    redirect    = 1'b1;
    redirect_pc = 16'h0ABC;
    cycle();
    redirect = 1'b0;
    check("rr_valid", instr_valid, 0);
    check("rr_req_low", request, 0);
    cycle();
    check("rr_req", request, 1);
    check("rr_addr", request_address, 16'h0ABC);
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    cycle();
    redirect = 1'b0;
    n = 0;
    while (popped.size() < 3 && n < 60) begin cycle(); n++; end
    check("wrap_found", n < 60, 1);
    check("wrap0", popped_at(0), 16'hFFFF);
    check("wrap1", popped_at(1), 16'h0000);
    check("wrap2", popped_at(2), 16'h0001);
    n = 0;
    while (!(request && !memory_ready) && n < 50) begin cycle(); n++; end
    check("midwait_found", n < 50, 1);
    reset = 1'b1;
    #1;
    check("arst_req", request, 0);
    check("arst_addr", request_address, 16'h0000);
    check("arst_valid", instr_valid, 0);
    cycle();
    reset = 1'b0;
    cycle();
    check("rst2_req", request, 1);
    check("rst2_addr", request_address, 16'h0000);
    rand_lat = 1'b1;
    noise    = 1'b1;
    start    = total_pops;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = $urandom_range(0, 3) != 0;
      redirect    = $urandom_range(0, 24) == 0;
      redirect_pc = $urandom_range(0, 1) ? 16'($urandom) : 16'hFFFF - 16'($urandom_range(0, 3));
      cycle();
    end
    redirect    = 1'b0;
    instr_ready = 1'b1;
    noise       = 1'b0;
    repeat (20) cycle();
    check("random_progress", (total_pops - start) > 100, 1);
    check("tie_type", request_type, 0);
    check("tie_dout", data_out, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
